// File: rtl/arc4_ctrl.sv
// arc4_ctrl: top-level sequencer for the ARC4 decryption datapath.
//
// Accepts a start request with a key. Then it runs the init, ksa and prga
// engines one after another, each through an en/rdy handshake. While an
// engine's phase is active, that engine owns the write/address port of the
// single-port S memory. The block also counts the cycles of each run for
// bring-up.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   en / rdy              start request / idle and able to accept en
//   key / key_q           key input / key latched when en is accepted
//   init_en/ksa_en/prga_en      one-cycle engine start pulses
//   init_rdy/ksa_rdy/prga_rdy   engine ready inputs
//   *_addr/*_wrdata/*_wren      per-engine S memory write port requests
//   s_addr/s_wrdata/s_wren      granted S memory write port
//   phase                 0 idle, 1 init, 2 ksa, 3 prga
//   cycles                cycles of the last or current run, saturating
module arc4_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int KEY_W  = 24,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  input  logic [KEY_W-1:0]  key,
  output logic [KEY_W-1:0]  key_q,
  output logic              init_en,
  output logic              ksa_en,
  output logic              prga_en,
  input  logic              init_rdy,
  input  logic              ksa_rdy,
  input  logic              prga_rdy,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [1:0]        phase,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [2:0] {
    IDLE,
    START_INIT,
    WAIT_INIT,
    START_KSA,
    WAIT_KSA,
    START_PRGA,
    WAIT_PRGA
  } state_t;

  state_t state, state_nxt;

  // The cycle counter runs on every edge outside IDLE and saturates at its
  // maximum value. Accepting a new run clears it. It holds its value in IDLE
  // so that the latency of the last run stays readable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      key_q  <= '0;
      cycles <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (en) begin
          key_q  <= key;
          cycles <= '0;
        end
      end else if (cycles != {CNT_W{1'b1}}) begin
        cycles <= cycles + CNT_W'(1);
      end
    end
  end

  // A START state fires its engine only once that engine reports ready. The
  // engine drops rdy on the edge that samples en, so WAIT sees rdy go low
  // first. WAIT then leaves on the first cycle rdy is high again. The start
  // pulses are masked while rst is high, so that no engine gets started on
  // the same edge that aborts the run.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    init_en   = 1'b0;
    ksa_en    = 1'b0;
    prga_en   = 1'b0;
    phase     = 2'd0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_nxt = START_INIT;
      end
      START_INIT: begin
        phase = 2'd1;
        if (init_rdy) begin
          init_en   = 1'b1;
          state_nxt = WAIT_INIT;
        end
      end
      WAIT_INIT: begin
        phase = 2'd1;
        if (init_rdy) state_nxt = START_KSA;
      end
      START_KSA: begin
        phase = 2'd2;
        if (ksa_rdy) begin
          ksa_en    = 1'b1;
          state_nxt = WAIT_KSA;
        end
      end
      WAIT_KSA: begin
        phase = 2'd2;
        if (ksa_rdy) state_nxt = START_PRGA;
      end
      START_PRGA: begin
        phase = 2'd3;
        if (prga_rdy) begin
          prga_en   = 1'b1;
          state_nxt = WAIT_PRGA;
        end
      end
      WAIT_PRGA: begin
        phase = 2'd3;
        if (prga_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      init_en = 1'b0;
      ksa_en  = 1'b0;
      prga_en = 1'b0;
    end
  end

  // The memory grant follows the phase of the current owner. In IDLE the
  // port is parked at zero, so that a stray engine write enable can never
  // reach the memory.
  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (phase)
      2'd1: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      2'd2: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      2'd3: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arc4_ctrl.sv
// tb_arc4_ctrl: bench for arc4_ctrl with stub engines.
//
// Each stub engine drops rdy for a programmable L cycles after its en pulse.
// A phase-level reference model predicts rdy, phase, the start pulses, the
// memory grant, key_q and cycles on every cycle. Directed runs add literal
// expectations on top of the model.
module tb_arc4_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [23:0] key_q;
  logic        init_en, ksa_en, prga_en;
  logic        init_rdy, ksa_rdy, prga_rdy;
  logic [7:0]  init_addr, ksa_addr, prga_addr;
  logic [7:0]  init_wrdata, ksa_wrdata, prga_wrdata;
  logic        init_wren, ksa_wren, prga_wren;
  logic [7:0]  s_addr;
  logic [7:0]  s_wrdata;
  logic        s_wren;
  logic [1:0]  phase;
  logic [15:0] cycles;

  int checks = 0;
  int failures = 0;

  arc4_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_q(key_q),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .phase(phase), .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub engines: rdy is low for l_* cycles after the edge that samples en.
  int l_init, l_ksa, l_prga;
  int rem_init = 0, rem_ksa = 0, rem_prga = 0;

  always @(posedge clk) begin
    if (rst) begin
      rem_init <= 0; rem_ksa <= 0; rem_prga <= 0;
    end else begin
      if (init_en) rem_init <= l_init; else if (rem_init > 0) rem_init <= rem_init - 1;
      if (ksa_en)  rem_ksa  <= l_ksa;  else if (rem_ksa > 0)  rem_ksa  <= rem_ksa - 1;
      if (prga_en) rem_prga <= l_prga; else if (rem_prga > 0) rem_prga <= rem_prga - 1;
    end
  end
  assign init_rdy = (rem_init == 0);
  assign ksa_rdy  = (rem_ksa == 0);
  assign prga_rdy = (rem_prga == 0);

  // Engine memory requests are random by default and fixed in directed windows.
  logic       fixed_mode;
  logic [7:0] f_init_addr, f_ksa_addr, f_prga_addr;
  logic [7:0] f_init_wrdata, f_ksa_wrdata, f_prga_wrdata;
  logic       f_init_wren, f_ksa_wren, f_prga_wren;
  logic [7:0] r_init_addr = 0, r_ksa_addr = 0, r_prga_addr = 0;
  logic [7:0] r_init_wrdata = 0, r_ksa_wrdata = 0, r_prga_wrdata = 0;
  logic       r_init_wren = 0, r_ksa_wren = 0, r_prga_wren = 0;

  always @(posedge clk) begin
    #1;
    r_init_addr = 8'($urandom);  r_init_wrdata = 8'($urandom);  r_init_wren = 1'($urandom);
    r_ksa_addr  = 8'($urandom);  r_ksa_wrdata  = 8'($urandom);  r_ksa_wren  = 1'($urandom);
    r_prga_addr = 8'($urandom);  r_prga_wrdata = 8'($urandom);  r_prga_wren = 1'($urandom);
  end

  assign init_addr   = fixed_mode ? f_init_addr   : r_init_addr;
  assign init_wrdata = fixed_mode ? f_init_wrdata : r_init_wrdata;
  assign init_wren   = fixed_mode ? f_init_wren   : r_init_wren;
  assign ksa_addr    = fixed_mode ? f_ksa_addr    : r_ksa_addr;
  assign ksa_wrdata  = fixed_mode ? f_ksa_wrdata  : r_ksa_wrdata;
  assign ksa_wren    = fixed_mode ? f_ksa_wren    : r_ksa_wren;
  assign prga_addr   = fixed_mode ? f_prga_addr   : r_prga_addr;
  assign prga_wrdata = fixed_mode ? f_prga_wrdata : r_prga_wrdata;
  assign prga_wren   = fixed_mode ? f_prga_wren   : r_prga_wren;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model at phase level. It tracks the current phase (0..3) and
  // whether that phase's engine has already been started. It also tracks a
  // plain saturating integer run counter and the latched key.
  int          m_phase = 0;
  bit          m_started = 0;
  int          m_cycles = 0;
  logic [23:0] m_key = 0;
  bit          m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_started <= 0; m_cycles <= 0; m_key <= 0; m_valid <= 1;
    end else if (m_phase == 0) begin
      if (en) begin
        m_key <= key; m_cycles <= 0; m_phase <= 1; m_started <= 0;
      end
    end else begin
      logic er;
      er = (m_phase == 1) ? init_rdy : (m_phase == 2) ? ksa_rdy : prga_rdy;
      m_cycles <= (m_cycles + 1 > 65535) ? 65535 : m_cycles + 1;
      if (!m_started) begin
        if (er) m_started <= 1;
      end else if (er) begin
        m_phase <= (m_phase == 3) ? 0 : m_phase + 1;
        m_started <= 0;
      end
    end
  end

  // Pulse bookkeeping and every-cycle comparison on the falling edge.
  int cyc = 0;
  int n_init = 0, n_ksa = 0, n_prga = 0;
  int t_init = 0, t_ksa = 0, t_prga = 0;
  bit prev_en = 0;

  always @(negedge clk) begin
    cyc++;
    if (m_valid) begin
      logic       xi, xk, xp, xw;
      logic [7:0] xa, xd;
      xi = !rst && m_phase == 1 && !m_started && init_rdy;
      xk = !rst && m_phase == 2 && !m_started && ksa_rdy;
      xp = !rst && m_phase == 3 && !m_started && prga_rdy;
      case (m_phase)
        1: begin xa = init_addr; xd = init_wrdata; xw = init_wren; end
        2: begin xa = ksa_addr;  xd = ksa_wrdata;  xw = ksa_wren;  end
        3: begin xa = prga_addr; xd = prga_wrdata; xw = prga_wren; end
        default: begin xa = 8'h00; xd = 8'h00; xw = 1'b0; end
      endcase
      checkOutput("rdy",      32'(rdy),      32'(m_phase == 0));
      checkOutput("phase",    32'(phase),    32'(m_phase));
      checkOutput("init_en",  32'(init_en),  32'(xi));
      checkOutput("ksa_en",   32'(ksa_en),   32'(xk));
      checkOutput("prga_en",  32'(prga_en),  32'(xp));
      checkOutput("s_addr",   32'(s_addr),   32'(xa));
      checkOutput("s_wrdata", 32'(s_wrdata), 32'(xd));
      checkOutput("s_wren",   32'(s_wren),   32'(xw));
      checkOutput("key_q",    32'(key_q),    32'(m_key));
      checkOutput("cycles",   32'(cycles),   32'(m_cycles));
      if (init_en || ksa_en || prga_en) checkOutput("en_spacing", 32'(prev_en), 32'd0);
    end
    if (init_en === 1'b1) begin n_init++; t_init = cyc; end
    if (ksa_en  === 1'b1) begin n_ksa++;  t_ksa  = cyc; end
    if (prga_en === 1'b1) begin n_prga++; t_prga = cyc; end
    prev_en = (init_en === 1'b1) || (ksa_en === 1'b1) || (prga_en === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [23:0] k);
    en = 1'b1;
    key = k;
    tick();
    en = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while (rdy !== 1'b1 && n < budget) begin tick(); n++; end
    checkOutput(name, 32'(rdy), 32'd1);
  endtask

  task automatic waitPhase(input logic [1:0] p, input int budget, input string name);
    int n = 0;
    while (phase !== p && n < budget) begin tick(); n++; end
    checkOutput(name, 32'(phase), 32'(p));
  endtask

  int b_init, b_ksa, b_prga;

  task automatic snapCounts();
    b_init = n_init; b_ksa = n_ksa; b_prga = n_prga;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; key = 24'h0;
    l_init = 1; l_ksa = 1; l_prga = 1;
    fixed_mode = 1'b0;
    f_init_addr = 8'h10; f_init_wrdata = 8'h10; f_init_wren = 1'b1;
    f_ksa_addr  = 8'h55; f_ksa_wrdata  = 8'hAA; f_ksa_wren  = 1'b1;
    f_prga_addr = 8'h77; f_prga_wrdata = 8'h99; f_prga_wren = 1'b1;

    // Reset values.
    repeat (2) tick();
    #1;
    checkOutput("rst_rdy",    32'(rdy),    32'd1);
    checkOutput("rst_phase",  32'(phase),  32'd0);
    checkOutput("rst_en",     32'({init_en, ksa_en, prga_en}), 32'd0);
    checkOutput("rst_s_wren", 32'(s_wren), 32'd0);
    checkOutput("rst_cycles", 32'(cycles), 32'd0);
    checkOutput("rst_key_q",  32'(key_q),  32'd0);
    rst = 1'b0;
    tick();

    // Full run 256/768/100 with grant isolation during init.
    l_init = 256; l_ksa = 768; l_prga = 100;
    fixed_mode = 1'b1;
    snapCounts();
    applyStimulus(24'h0000AA);
    tick(); tick();
    #1;
    checkOutput("grant_phase",  32'(phase),    32'd1);
    checkOutput("grant_addr",   32'(s_addr),   32'h10);
    checkOutput("grant_wrdata", 32'(s_wrdata), 32'h10);
    checkOutput("grant_wren1",  32'(s_wren),   32'd1);
    f_init_wren = 1'b0;
    #1;
    checkOutput("grant_wren0",  32'(s_wren),   32'd0);
    f_init_wren = 1'b1;
    fixed_mode = 1'b0;
    waitIdle(2000, "run1_done");
    checkOutput("run1_cycles", 32'(cycles), 32'd1130);
    checkOutput("run1_key_q",  32'(key_q),  32'h0000AA);
    checkOutput("run1_n_init", 32'(n_init - b_init), 32'd1);
    checkOutput("run1_n_ksa",  32'(n_ksa - b_ksa),   32'd1);
    checkOutput("run1_n_prga", 32'(n_prga - b_prga), 32'd1);
    checkOutput("run1_order",  32'(t_init < t_ksa && t_ksa < t_prga), 32'd1);

    // Back-to-back run with a busy start request during WAIT_KSA.
    l_init = 5; l_ksa = 50; l_prga = 5;
    snapCounts();
    applyStimulus(24'hABCDEF);
    waitPhase(2'd2, 100, "run2_reach_ksa");
    repeat (3) tick();
    en = 1'b1; key = 24'h123456;
    tick();
    en = 1'b0;
    #1;
    checkOutput("busy_key_q", 32'(key_q), 32'hABCDEF);
    checkOutput("busy_phase", 32'(phase), 32'd2);
    checkOutput("busy_rdy",   32'(rdy),   32'd0);
    waitIdle(500, "run2_done");
    checkOutput("run2_cycles", 32'(cycles), 32'd66);
    checkOutput("run2_n_init", 32'(n_init - b_init), 32'd1);
    checkOutput("run2_n_ksa",  32'(n_ksa - b_ksa),   32'd1);
    checkOutput("run2_n_prga", 32'(n_prga - b_prga), 32'd1);

    // Reset during WAIT_KSA, then a normal run.
    snapCounts();
    applyStimulus(24'h00C0DE);
    waitPhase(2'd2, 100, "run3_reach_ksa");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    #1;
    checkOutput("mid_rst_rdy",    32'(rdy),    32'd1);
    checkOutput("mid_rst_phase",  32'(phase),  32'd0);
    checkOutput("mid_rst_s_wren", 32'(s_wren), 32'd0);
    checkOutput("mid_rst_cycles", 32'(cycles), 32'd0);
    rst = 1'b0;
    repeat (60) tick();
    checkOutput("mid_rst_no_prga", 32'(n_prga - b_prga), 32'd0);
    l_init = 3; l_ksa = 3; l_prga = 3;
    applyStimulus(24'h00C0DE);
    waitIdle(200, "run4_done");
    checkOutput("run4_cycles", 32'(cycles), 32'd15);
    checkOutput("run4_key_q",  32'(key_q),  32'h00C0DE);

    // Saturation with a long prga.
    l_init = 4; l_ksa = 4; l_prga = 70000;
    applyStimulus(24'h5A5A5A);
    waitIdle(72000, "run5_done");
    checkOutput("sat_cycles", 32'(cycles), 32'hFFFF);
    repeat (3) tick();
    checkOutput("sat_hold",   32'(cycles), 32'hFFFF);
    checkOutput("sat_rdy",    32'(rdy),    32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
